// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: round-robin grant, registered
// operand and result stages, and a private carry flag per requester feeding RRC carry-in.
module alu_share_ctrl #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned OP_W    = 3,
    parameter bit          RR_INIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*OP_W-1:0]     req_op,
    input  logic [2*WIDTH-1:0]    req_a,
    input  logic [2*WIDTH-1:0]    req_b,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [WIDTH-1:0]      rsp_r,
    output logic                  rsp_c,
    output logic                  rsp_z,
    output logic [1:0]            cflag,
    output logic                  busy,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [OP_W-1:0]       alu_sel,
    output logic                  alu_cin,
    input  logic [WIDTH-1:0]      alu_r,
    input  logic                  alu_c,
    input  logic                  alu_z
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]       state_q;
    logic             prio_q;
    logic             gnt_q;
    logic [1:0]       cflag_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [OP_W-1:0]  alu_sel_q;
    logic             alu_cin_q;
    logic [WIDTH-1:0] rsp_r_q;
    logic             rsp_c_q;
    logic             rsp_z_q;

    logic             grant;
    logic [OP_W-1:0]  sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Priority holder only matters when both requesters are valid.
    always_comb begin
        grant = prio_q;
        unique case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = prio_q;
        endcase
        req_ready = 2'b00;
        if (state_q == StIdle && req_valid != 2'b00) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
    end

    assign sel_op = grant ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
    assign sel_a  = grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign sel_b  = grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            prio_q    <= RR_INIT;
            gnt_q     <= 1'b0;
            cflag_q   <= 2'b00;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            alu_cin_q <= 1'b0;
            rsp_r_q   <= '0;
            rsp_c_q   <= 1'b0;
            rsp_z_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid != 2'b00) begin
                        alu_sel_q <= sel_op;
                        alu_a_q   <= sel_a;
                        alu_b_q   <= sel_b;
                        alu_cin_q <= cflag_q[grant];
                        gnt_q     <= grant;
                        prio_q    <= ~grant;
                        state_q   <= StExec;
                    end
                end
                StExec: begin
                    rsp_r_q        <= alu_r;
                    rsp_c_q        <= alu_c;
                    rsp_z_q        <= alu_z;
                    cflag_q[gnt_q] <= alu_c;
                    state_q        <= StResp;
                end
                StResp: begin
                    if (rsp_ready[gnt_q]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid = (state_q == StResp) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state_q != StIdle);
    assign rsp_r     = rsp_r_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_z     = rsp_z_q;
    assign cflag     = cflag_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign alu_cin   = alu_cin_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: behavioural ALU, scoreboard of expected
// responses per accepted request, and one task per scenario.
module tb_alu_share_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_r;
    logic        rsp_c;
    logic        rsp_z;
    logic [1:0]  cflag;
    logic        busy;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_sel;
    logic        alu_cin;
    logic [15:0] alu_r;
    logic        alu_c;
    logic        alu_z;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [18:0] sb[$];       // {id, z, c, r}
    int          gnt_log[$];
    int          gnt_cyc[$];
    logic [1:0]  m_cflag;

    alu_share_ctrl #(.WIDTH(16), .OP_W(3), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r(rsp_r), .rsp_c(rsp_c), .rsp_z(rsp_z),
        .cflag(cflag), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_r(alu_r), .alu_c(alu_c), .alu_z(alu_z)
    );

    // Returns {z, c, r}.
    function automatic logic [17:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
        logic [16:0] w;
        logic [15:0] r;
        logic        c;
        case (op)
            3'b000:  w = {1'b0, a} + {1'b0, b};
            3'b001:  w = {1'b0, a} - {1'b0, b};
            3'b010:  w = {1'b0, a} + 17'd1;
            3'b011:  w = {1'b0, a} - 17'd1;
            3'b100:  w = {a, 1'b0};
            3'b101:  w = {a[0], cin, a[15:1]};
            default: w = 17'd0;
        endcase
        r = w[15:0];
        c = w[16];
        return {(r == 16'd0), c, r};
    endfunction

    assign {alu_z, alu_c, alu_r} = alu_fn(alu_sel, alu_a, alu_b, alu_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor; inputs change just after posedge, so negedge sees handshake values.
    always @(negedge clk) begin
        logic [17:0] e;
        logic [18:0] x;
        cyc = cyc + 1;
        if (!rst_n) begin
            sb.delete();
            m_cflag = 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e = alu_fn(req_op[3*i +: 3], req_a[16*i +: 16], req_b[16*i +: 16],
                               m_cflag[i]);
                    m_cflag[i] = e[16];
                    sb.push_back({1'(i), e});
                    gnt_log.push_back(i);
                    gnt_cyc.push_back(cyc);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard_empty: response on port %0d with nothing expected", i);
                    end else begin
                        x = sb.pop_front();
                        if ({1'(i), rsp_z, rsp_c, rsp_r} !== x) begin
                            errors++;
                            $display("FAIL scoreboard: got id/z/c/r=%0d/%b/%b/%h expected %0d/%b/%b/%h",
                                     i, rsp_z, rsp_c, rsp_r, x[18], x[17], x[16], x[15:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int i, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b);
        bit got;
        @(posedge clk); #1;
        req_valid[i]        = 1'b1;
        req_op[3*i +: 3]    = op;
        req_a[16*i +: 16]   = a;
        req_b[16*i +: 16]   = b;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: requester %0d got no req_ready, required within 20 cycles", i);
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 50 && !idle; k++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still 1, required 0 within 50 cycles");
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [69:0] outs;
        outs = {req_ready, rsp_valid, rsp_r, rsp_c, rsp_z, cflag, busy, alu_a, alu_b, alu_sel, alu_cin};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_initial: outputs=%h required 0", outs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 2'b00;
        issue(0, 3'b001, 16'h0005, 16'h0003);
        // Now in EXEC with live operands; reset must clear everything immediately.
        rst_n = 1'b0;
        #1;
        outs = {req_ready, rsp_valid, rsp_r, rsp_c, rsp_z, cflag, busy, alu_a, alu_b, alu_sel, alu_cin};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_mid_exec: outputs=%h required 0", outs);
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_stale: rsp_valid=%b busy=%b required 00/0", rsp_valid, busy);
            end
        end
    endtask

    task automatic test_add_carry();
        rsp_ready = 2'b00;
        issue(0, 3'b000, 16'hFFFF, 16'h0001);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL add_exec: rsp_valid=%b busy=%b required 00/1", rsp_valid, busy);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_r, rsp_c, rsp_z, cflag} !== {2'b01, 16'h0000, 1'b1, 1'b1, 2'b01}) begin
            errors++;
            $display("FAIL add_resp: valid=%b r=%h c=%b z=%b cflag=%b required 01/0000/1/1/01",
                     rsp_valid, rsp_r, rsp_c, rsp_z, cflag);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b01;
        wait_idle();
    endtask

    task automatic test_rrc();
        rsp_ready = 2'b11;
        issue(0, 3'b101, 16'h0002, 16'h0000);
        @(negedge clk);
        checks++;
        if ({alu_cin, alu_sel, alu_a} !== {1'b1, 3'b101, 16'h0002}) begin
            errors++;
            $display("FAIL rrc0_alu_in: cin/sel/a=%b/%b/%h required 1/101/0002", alu_cin, alu_sel, alu_a);
        end
        @(negedge clk);
        checks++;
        if ({rsp_r, rsp_c, cflag[0]} !== {16'h8001, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rrc0_resp: r=%h c=%b cflag0=%b required 8001/0/0", rsp_r, rsp_c, cflag[0]);
        end
        wait_idle();
        issue(1, 3'b101, 16'h0002, 16'h0000);
        @(negedge clk);
        checks++;
        if (alu_cin !== 1'b0) begin
            errors++;
            $display("FAIL rrc1_cin: alu_cin=%b required 0", alu_cin);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_r} !== {2'b10, 16'h0001}) begin
            errors++;
            $display("FAIL rrc1_resp: valid=%b r=%h required 10/0001", rsp_valid, rsp_r);
        end
        wait_idle();
    endtask

    task automatic test_round_robin();
        do_reset();
        gnt_log.delete();
        gnt_cyc.delete();
        rsp_ready = 2'b11;
        req_op    = {3'b010, 3'b000};
        req_a     = {16'h00F0, 16'h1000};
        req_b     = {16'h0000, 16'h0234};
        req_valid = 2'b11;
        repeat (14) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_idle();
        checks++;
        if (gnt_log.size() < 4) begin
            errors++;
            $display("FAIL rr_count: %0d accepts, required at least 4", gnt_log.size());
        end
        for (int k = 0; k < gnt_log.size(); k++) begin
            checks++;
            if (gnt_log[k] != k % 2) begin
                errors++;
                $display("FAIL rr_order: grant %0d went to %0d, required %0d", k, gnt_log[k], k % 2);
            end
            if (k > 0) begin
                checks++;
                if (gnt_cyc[k] - gnt_cyc[k-1] != 3) begin
                    errors++;
                    $display("FAIL rr_spacing: accept gap %0d cycles, required 3",
                             gnt_cyc[k] - gnt_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 2'b00;
        issue(1, 3'b100, 16'h8001, 16'h0000);
        @(negedge clk);
        req_op[2:0]  = 3'b000;
        req_a[15:0]  = 16'hFFFF;
        req_b[15:0]  = 16'h0001;
        req_valid[0] = 1'b1;
        rsp_ready    = 2'b01;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_r, rsp_c, rsp_z, req_ready} !== {2'b10, 16'h0002, 1'b1, 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold: valid=%b r=%h c=%b z=%b ready=%b required 10/0002/1/0/00",
                         rsp_valid, rsp_r, rsp_c, rsp_z, req_ready);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_bubble: req_ready=%b required 00 in handshake cycle", req_ready);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, req_ready} !== {2'b00, 2'b01}) begin
            errors++;
            $display("FAIL bp_release: rsp_valid=%b req_ready=%b required 00/01", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_idle();
    endtask

    task automatic test_clear_op();
        checks++;
        if (cflag !== 2'b11) begin
            errors++;
            $display("FAIL clr_pre: cflag=%b required 11", cflag);
        end
        rsp_ready = 2'b11;
        issue(0, 3'b110, 16'h1234, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_r, rsp_c, rsp_z, cflag} !== {16'h0000, 1'b0, 1'b1, 2'b10}) begin
            errors++;
            $display("FAIL clr_op110: r=%h c=%b z=%b cflag=%b required 0000/0/1/10",
                     rsp_r, rsp_c, rsp_z, cflag);
        end
        wait_idle();
        issue(1, 3'b111, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (cflag !== 2'b00) begin
            errors++;
            $display("FAIL clr_op111: cflag=%b required 00", cflag);
        end
        wait_idle();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 2'b00;
        m_cflag   = 2'b00;
        #2;
        test_reset();
        test_add_carry();
        test_rrc();
        test_round_robin();
        test_backpressure();
        test_clear_op();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
